// File: rtl/lsu_pkg.sv
// lsu_pkg -- shared definitions for the load/store unit.
//   * access size encodings (funct3 style)
//   * fault cause codes reported alongside the done pulse
//   * FSM state enum
//   * access_fault(): classifies a request as legal, misaligned or illegal
package lsu_pkg;

  localparam logic [2:0] SZ_B  = 3'b000;
  localparam logic [2:0] SZ_H  = 3'b001;
  localparam logic [2:0] SZ_W  = 3'b010;
  localparam logic [2:0] SZ_BU = 3'b100;
  localparam logic [2:0] SZ_HU = 3'b101;

  localparam logic [1:0] CAUSE_NONE     = 2'b00;
  localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT  = 2'b10;
  localparam logic [1:0] CAUSE_ILLEGAL  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_DONE = 2'b10
  } lsu_state_e;

  // Illegal outranks misaligned: a store of an unsigned size is illegal even
  // when its address would also be misaligned.
  function automatic logic [1:0] access_fault(input logic       rd,
                                              input logic       wr,
                                              input logic [2:0] size,
                                              input logic [1:0] off);
    logic [1:0] cause;
    cause = CAUSE_NONE;
    if (rd && wr) begin
      cause = CAUSE_ILLEGAL;
    end else begin
      case (size)
        SZ_B, SZ_BU: cause = CAUSE_NONE;
        SZ_H, SZ_HU: cause = off[0] ? CAUSE_MISALIGN : CAUSE_NONE;
        SZ_W:        cause = (off != 2'b00) ? CAUSE_MISALIGN : CAUSE_NONE;
        default:     cause = CAUSE_ILLEGAL;
      endcase
      if (wr && size[2]) begin
        cause = CAUSE_ILLEGAL;
      end else begin
        cause = cause;
      end
    end
    return cause;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// lsu_align -- purely combinational sub-word formatting for the LSU.
// Store side:
//   st_size, st_off, st_data  -> st_wstrb (byte lanes), st_wdata (lane-replicated)
// Load side:
//   ld_size, ld_off, ld_rdata -> ld_value (lane extracted, sign/zero extended)
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  st_size,
  input  logic [1:0]  st_off,
  input  logic [31:0] st_data,
  output logic [3:0]  st_wstrb,
  output logic [31:0] st_wdata,
  input  logic [2:0]  ld_size,
  input  logic [1:0]  ld_off,
  input  logic [31:0] ld_rdata,
  output logic [31:0] ld_value
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Store strobes and replicated write data; data is replicated so the memory
  // only has to honour the strobes.
  always_comb begin
    st_wstrb = 4'b0000;
    st_wdata = 32'h0000_0000;
    case (st_size)
      SZ_B: begin
        st_wstrb = 4'b0001 << st_off;
        st_wdata = {4{st_data[7:0]}};
      end
      SZ_H: begin
        st_wstrb = 4'b0011 << {st_off[1], 1'b0};
        st_wdata = {2{st_data[15:0]}};
      end
      SZ_W: begin
        st_wstrb = 4'b1111;
        st_wdata = st_data;
      end
      default: begin
        st_wstrb = 4'b0000;
        st_wdata = 32'h0000_0000;
      end
    endcase
  end

  // Load lane extraction followed by sign or zero extension.
  always_comb begin
    byte_s   = ld_rdata[{ld_off, 3'b000} +: 8];
    half_s   = ld_rdata[{ld_off[1], 4'b0000} +: 16];
    ld_value = 32'h0000_0000;
    case (ld_size)
      SZ_B:    ld_value = {{24{byte_s[7]}}, byte_s};
      SZ_BU:   ld_value = {24'h00_0000, byte_s};
      SZ_H:    ld_value = {{16{half_s[15]}}, half_s};
      SZ_HU:   ld_value = {16'h0000, half_s};
      SZ_W:    ld_value = ld_rdata;
      default: ld_value = 32'h0000_0000;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit -- sequencing data-memory stage.
// Runs one req/ack memory transaction per load or store, stalling the core
// until the access retires with a one-cycle done pulse.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   data_read_en, data_write_en   load / store request from decode
//   data_size, addr, store_data   funct3 size, byte address, rs2 value
//   load_data, stall, done        extended load result, core hold, retire pulse
//   fault, fault_cause            fault flag and cause, valid with done
//   mem_req, mem_we, mem_addr,
//   mem_wstrb, mem_wdata          registered memory request
//   mem_rdata, mem_ack            memory response
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int MAX_WAIT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        data_read_en,
  input  logic        data_write_en,
  input  logic [2:0]  data_size,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  output logic [31:0] load_data,
  output logic        stall,
  output logic        done,
  output logic        fault,
  output logic [1:0]  fault_cause,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
);

  // Counter value seen in the last REQ cycle before a timeout.
  localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

  lsu_state_e  state_r;
  logic [7:0]  wait_cnt_r;
  logic [2:0]  size_r;
  logic [1:0]  off_r;
  logic        access_s;
  logic [1:0]  req_cause_s;
  logic [3:0]  st_wstrb_s;
  logic [31:0] st_wdata_s;
  logic [31:0] ld_value_s;

  assign access_s    = data_read_en | data_write_en;
  assign req_cause_s = access_fault(data_read_en, data_write_en, data_size, addr[1:0]);

  // Store formatting works on the live request; load extraction uses the
  // size and offset latched at acceptance.
  lsu_align u_align (
    .st_size  (data_size),
    .st_off   (addr[1:0]),
    .st_data  (store_data),
    .st_wstrb (st_wstrb_s),
    .st_wdata (st_wdata_s),
    .ld_size  (size_r),
    .ld_off   (off_r),
    .ld_rdata (mem_rdata),
    .ld_value (ld_value_s)
  );

  // Core hold: only combinational path from the inputs.
  always_comb begin
    stall = 1'b0;
    case (state_r)
      ST_IDLE: stall = access_s;
      ST_REQ:  stall = 1'b1;
      ST_DONE: stall = 1'b0;
      default: stall = 1'b0;
    endcase
  end

  // Transaction FSM with registered memory-side and result outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      wait_cnt_r  <= 8'd0;
      size_r      <= 3'b000;
      off_r       <= 2'b00;
      load_data   <= 32'h0000_0000;
      done        <= 1'b0;
      fault       <= 1'b0;
      fault_cause <= CAUSE_NONE;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= 32'h0000_0000;
      mem_wstrb   <= 4'b0000;
      mem_wdata   <= 32'h0000_0000;
    end else begin
      case (state_r)
        ST_IDLE: begin
          done        <= 1'b0;
          fault       <= 1'b0;
          fault_cause <= CAUSE_NONE;
          wait_cnt_r  <= 8'd0;
          if (access_s) begin
            if (req_cause_s != CAUSE_NONE) begin
              // Faulty request retires without touching memory.
              state_r     <= ST_DONE;
              done        <= 1'b1;
              fault       <= 1'b1;
              fault_cause <= req_cause_s;
              load_data   <= 32'h0000_0000;
            end else begin
              state_r   <= ST_REQ;
              mem_req   <= 1'b1;
              mem_we    <= data_write_en;
              mem_addr  <= {addr[31:2], 2'b00};
              mem_wstrb <= data_write_en ? st_wstrb_s : 4'b0000;
              mem_wdata <= data_write_en ? st_wdata_s : 32'h0000_0000;
              size_r    <= data_size;
              off_r     <= addr[1:0];
            end
          end
        end
        ST_REQ: begin
          if (mem_ack) begin
            // An ack in the final wait cycle still completes the access.
            state_r     <= ST_DONE;
            mem_req     <= 1'b0;
            done        <= 1'b1;
            fault       <= 1'b0;
            fault_cause <= CAUSE_NONE;
            load_data   <= mem_we ? 32'h0000_0000 : ld_value_s;
            wait_cnt_r  <= 8'd0;
          end else if (wait_cnt_r == WAIT_LAST) begin
            state_r     <= ST_DONE;
            mem_req     <= 1'b0;
            done        <= 1'b1;
            fault       <= 1'b1;
            fault_cause <= CAUSE_TIMEOUT;
            load_data   <= 32'h0000_0000;
            wait_cnt_r  <= 8'd0;
          end else begin
            wait_cnt_r <= wait_cnt_r + 8'd1;
          end
        end
        ST_DONE: begin
          state_r     <= ST_IDLE;
          done        <= 1'b0;
          fault       <= 1'b0;
          fault_cause <= CAUSE_NONE;
        end
        default: begin
          state_r     <= ST_IDLE;
          mem_req     <= 1'b0;
          done        <= 1'b0;
          fault       <= 1'b0;
          fault_cause <= CAUSE_NONE;
        end
      endcase
    end
  end

endmodule
